// File: rtl/axis_multipass_framer_if.sv
// Pixel-stream bus for the multipass framer: upstream (s_axis_*) and downstream (m_axis_*) AXI4-Stream links.
// slave = the framer's view; master = the traffic source/sink that surrounds it.
interface axis_multipass_framer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic [1:0]        m_axis_tuser;
    logic              m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/axis_multipass_framer.sv
// AXI4-Stream framer: 1-deep register stage that counts rows/columns, generates SOF/EOL/TLAST
// sideband and sequences NUM_PASSES passes over the same image, flagging short/long upstream frames.
module axis_multipass_framer #(
    parameter int DATA_W      = 32,
    parameter int IMG_W       = 512,
    parameter int IMG_H       = 512,
    parameter int NUM_PASSES  = 2,
    parameter int GAP_CYCLES  = 0,
    parameter int CHECK_TLAST = 1
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          enable,
    axis_multipass_framer_if.slave        axis,
    output logic [3:0]                    pass_idx,
    output logic                          pass_done,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          err_short,
    output logic                          err_long
);
    localparam int CW       = $clog2(IMG_W);
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, STREAM, GAP, DRAIN} state_t;
    state_t state;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [GW-1:0]     gap_cnt;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic [1:0]        m_user;
    logic              m_pass_end;
    logic              m_frame_end;

    logic s_ready, accept, m_fire;
    logic last_col, last_row, final_pix, early, pass_end, final_pass;

    assign s_ready    = (state == STREAM) && (!m_valid || axis.m_axis_tready);
    assign accept     = s_ready && axis.s_axis_tvalid;
    assign m_fire     = m_valid && axis.m_axis_tready;
    assign last_col   = (col == CW'(IMG_W - 1));
    assign last_row   = (row == RW'(IMG_H - 1));
    assign final_pix  = last_col && last_row;
    // An early upstream TLAST closes the pass exactly like the final pixel would.
    assign early      = axis.s_axis_tlast && !final_pix;
    assign pass_end   = final_pix || early;
    assign final_pass = (pass_idx == 4'(NUM_PASSES - 1));

    assign axis.s_axis_tready = s_ready;
    assign axis.m_axis_tdata  = m_data;
    assign axis.m_axis_tvalid = m_valid;
    assign axis.m_axis_tlast  = m_last;
    assign axis.m_axis_tuser  = m_user;
    assign pass_done          = m_fire && m_pass_end;
    assign frame_done         = m_fire && m_frame_end;
    assign busy               = (state != IDLE);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            gap_cnt     <= '0;
            pass_idx    <= '0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            m_user      <= '0;
            m_pass_end  <= 1'b0;
            m_frame_end <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
        end else begin
            if (accept) begin
                m_data      <= axis.s_axis_tdata;
                m_valid     <= 1'b1;
                m_last      <= pass_end;
                m_user      <= {last_col || early, (col == '0) && (row == '0)};
                m_pass_end  <= pass_end;
                m_frame_end <= pass_end && final_pass;
            end else if (m_fire) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= STREAM;
                        err_short <= 1'b0;
                        err_long  <= 1'b0;
                        pass_idx  <= '0;
                        col       <= '0;
                        row       <= '0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (pass_end) begin
                            col <= '0;
                            row <= '0;
                        end else if (last_col) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        if (early) err_short <= 1'b1;
                        if ((CHECK_TLAST != 0) && final_pix && !axis.s_axis_tlast) err_long <= 1'b1;
                        if (pass_end) begin
                            if (final_pass) begin
                                state <= DRAIN;
                            end else begin
                                pass_idx <= pass_idx + 4'd1;
                                if (GAP_CYCLES > 0) begin
                                    state   <= GAP;
                                    gap_cnt <= '0;
                                end
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_LAST)) state <= STREAM;
                    else gap_cnt <= gap_cnt + GW'(1);
                end
                DRAIN: begin
                    if (m_fire) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_multipass_framer.sv
// Directed bench for axis_multipass_framer: main instance (4x2, 2 passes, gap 3), a CHECK_TLAST=0
// twin driven in lockstep, and a single-line single-pass instance with no gap.
module tb_axis_multipass_framer;
    logic ACLK = 1'b0;
    logic ARESETn;
    logic en_ab, en_c;
    always #5 ACLK = ~ACLK;

    axis_multipass_framer_if #(.DATA_W(32)) ia ();
    axis_multipass_framer_if #(.DATA_W(32)) ib ();
    axis_multipass_framer_if #(.DATA_W(32)) ic ();

    logic [3:0] pidx_a, pidx_b, pidx_c;
    logic pd_a, fd_a, busy_a, es_a, el_a;
    logic pd_b, fd_b, busy_b, es_b, el_b;
    logic pd_c, fd_c, busy_c, es_c, el_c;

    axis_multipass_framer #(.DATA_W(32), .IMG_W(4), .IMG_H(2), .NUM_PASSES(2), .GAP_CYCLES(3), .CHECK_TLAST(1)) dut_a (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(en_ab), .axis(ia),
        .pass_idx(pidx_a), .pass_done(pd_a), .frame_done(fd_a), .busy(busy_a),
        .err_short(es_a), .err_long(el_a));

    axis_multipass_framer #(.DATA_W(32), .IMG_W(4), .IMG_H(2), .NUM_PASSES(2), .GAP_CYCLES(3), .CHECK_TLAST(0)) dut_b (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(en_ab), .axis(ib),
        .pass_idx(pidx_b), .pass_done(pd_b), .frame_done(fd_b), .busy(busy_b),
        .err_short(es_b), .err_long(el_b));

    axis_multipass_framer #(.DATA_W(32), .IMG_W(4), .IMG_H(1), .NUM_PASSES(1), .GAP_CYCLES(0), .CHECK_TLAST(1)) dut_c (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(en_c), .axis(ic),
        .pass_idx(pidx_c), .pass_done(pd_c), .frame_done(fd_c), .busy(busy_c),
        .err_short(es_c), .err_long(el_c));

    assign ib.s_axis_tdata  = ia.s_axis_tdata;
    assign ib.s_axis_tvalid = ia.s_axis_tvalid;
    assign ib.s_axis_tlast  = ia.s_axis_tlast;
    assign ib.m_axis_tready = ia.m_axis_tready;

    int errors = 0;
    int checks = 0;

`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

    logic [31:0] out_data [32];
    logic [1:0]  out_user [32];
    logic        out_last [32];
    int          out_cyc  [32];
    int          acc_cyc  [32];
    logic [3:0]  acc_pidx [32];
    int          out_n, pd_n, fd_beat, stall_bad;
    bit          timed_out;

    // Drives one frame on ia beat by beat and records both sides of the handshake per cycle.
    task automatic run_frame(input int nb, input logic [31:0] tl_mask, input bit tog, input bit wait_done);
        int sent = 0;
        int cyc = 0;
        bit done = 0;
        bit have_stall = 0;
        logic [31:0] st_d = '0;
        logic [1:0]  st_u = '0;
        logic        st_l = 1'b0;
        out_n = 0; pd_n = 0; fd_beat = -1; stall_bad = 0;
        en_ab = 1'b1;
        @(posedge ACLK); #1;
        en_ab = 1'b0;
        while (!done && cyc < 200) begin
            ia.s_axis_tvalid = (sent < nb);
            ia.s_axis_tdata  = 32'(sent + 1);
            ia.s_axis_tlast  = tl_mask[sent];
            ia.m_axis_tready = tog ? (cyc % 2 == 0) : 1'b1;
            @(negedge ACLK);
            if (have_stall && (ia.m_axis_tdata !== st_d || ia.m_axis_tuser !== st_u ||
                               ia.m_axis_tlast !== st_l || ia.m_axis_tvalid !== 1'b1))
                stall_bad++;
            have_stall = ia.m_axis_tvalid && !ia.m_axis_tready;
            st_d = ia.m_axis_tdata; st_u = ia.m_axis_tuser; st_l = ia.m_axis_tlast;
            if (ia.m_axis_tvalid && ia.m_axis_tready) begin
                out_data[out_n] = ia.m_axis_tdata;
                out_user[out_n] = ia.m_axis_tuser;
                out_last[out_n] = ia.m_axis_tlast;
                out_cyc[out_n]  = cyc;
                if (pd_a) pd_n++;
                if (fd_a) begin
                    fd_beat = out_n;
                    if (wait_done) done = 1;
                end
                out_n++;
            end
            if (ia.s_axis_tvalid && ia.s_axis_tready) begin
                acc_cyc[sent]  = cyc;
                acc_pidx[sent] = pidx_a;
                sent++;
                if (!wait_done && sent == nb) done = 1;
            end
            @(posedge ACLK); #1;
            cyc++;
        end
        ia.s_axis_tvalid = 1'b0;
        ia.s_axis_tlast  = 1'b0;
        ia.m_axis_tready = 1'b1;
        timed_out = !done;
    endtask

    function automatic int beats_bad(input int n, input logic [15:0] sofm, input logic [15:0] eolm,
                                     input logic [15:0] tlm);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (out_data[i] !== 32'(i + 1)) bad++;
            if (out_user[i][0] !== sofm[i]) bad++;
            if (out_user[i][1] !== eolm[i]) bad++;
            if (out_last[i] !== tlm[i]) bad++;
        end
        return bad;
    endfunction

    function automatic int pidx_bad(input int n, input logic [15:0] p1m);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (acc_pidx[i] !== {3'b000, p1m[i]}) bad++;
        return bad;
    endfunction

    initial begin
        int  sent;
        bit  fdone, got_first;
        logic [1:0]  first_user;
        logic        pd_at_fd, tl_at_fd;
        logic [31:0] d_at_fd;

        ARESETn = 1'b0; en_ab = 1'b0; en_c = 1'b0;
        ia.s_axis_tvalid = 1'b0; ia.s_axis_tdata = '0; ia.s_axis_tlast = 1'b0; ia.m_axis_tready = 1'b1;
        ic.s_axis_tvalid = 1'b0; ic.s_axis_tdata = '0; ic.s_axis_tlast = 1'b0; ic.m_axis_tready = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        `CHK("rst_mvalid", ia.m_axis_tvalid, 1'b0)
        `CHK("rst_sready", ia.s_axis_tready, 1'b0)
        `CHK("rst_busy", busy_a, 1'b0)
        `CHK("rst_pidx", pidx_a, 4'd0)
        `CHK("rst_tuser", ia.m_axis_tuser, 2'b00)
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // Test 1: nominal two-pass frame, continuous ready
        run_frame(16, 32'h0000_8080, 1'b0, 1'b1);
        `CHK("t1_timeout", timed_out, 1'b0)
        `CHK("t1_count", out_n, 16)
        `CHK("t1_beats", beats_bad(16, 16'h0101, 16'h8888, 16'h8080), 0)
        `CHK("t1_pidx", pidx_bad(16, 16'hFF00), 0)
        `CHK("t1_pass_done", pd_n, 2)
        `CHK("t1_frame_done_beat", fd_beat, 15)
        `CHK("t1_gap_len", acc_cyc[8] - acc_cyc[7], 4)
        `CHK("t1_throughput", acc_cyc[1] - acc_cyc[0], 1)
        `CHK("t1_latency", out_cyc[0] - acc_cyc[0], 1)
        `CHK("t1_busy_after", busy_a, 1'b0)
        `CHK("t1_err_short", es_a, 1'b0)
        `CHK("t1_err_long", el_a, 1'b0)
        @(posedge ACLK); #1;

        // Test 2: output back-pressure 1010...
        run_frame(16, 32'h0000_8080, 1'b1, 1'b1);
        `CHK("t2_timeout", timed_out, 1'b0)
        `CHK("t2_count", out_n, 16)
        `CHK("t2_beats", beats_bad(16, 16'h0101, 16'h8888, 16'h8080), 0)
        `CHK("t2_stall_stable", stall_bad, 0)
        `CHK("t2_pass_done", pd_n, 2)
        @(posedge ACLK); #1;

        // Test 3: early upstream TLAST on beat 5 of pass 0
        run_frame(13, 32'h0000_1010, 1'b0, 1'b1);
        `CHK("t3_timeout", timed_out, 1'b0)
        `CHK("t3_count", out_n, 13)
        `CHK("t3_beats", beats_bad(13, 16'h0021, 16'h1118, 16'h1010), 0)
        `CHK("t3_pidx", pidx_bad(13, 16'h1FE0), 0)
        `CHK("t3_err_short", es_a, 1'b1)
        `CHK("t3_err_long", el_a, 1'b0)
        `CHK("t3_frame_done_beat", fd_beat, 12)
        `CHK("t3_gap_len", acc_cyc[5] - acc_cyc[4], 4)
        @(posedge ACLK); #1;

        // Test 4: no upstream TLAST at all
        run_frame(16, 32'h0000_0000, 1'b0, 1'b1);
        `CHK("t4_timeout", timed_out, 1'b0)
        `CHK("t4_beats", beats_bad(16, 16'h0101, 16'h8888, 16'h8080), 0)
        `CHK("t4_err_long_chk1", el_a, 1'b1)
        `CHK("t4_err_long_chk0", el_b, 1'b0)
        `CHK("t4_err_short_cleared", es_a, 1'b0)
        `CHK("t4_frame_done_beat", fd_beat, 15)
        @(posedge ACLK); #1;

        // Test 5: reset mid-frame after beat 6, then restart
        run_frame(6, 32'h0000_0000, 1'b0, 1'b0);
        `CHK("t5_pre_mvalid", ia.m_axis_tvalid, 1'b1)
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        `CHK("t5_mvalid", ia.m_axis_tvalid, 1'b0)
        `CHK("t5_mdata", ia.m_axis_tdata, 32'h0)
        `CHK("t5_tuser", ia.m_axis_tuser, 2'b00)
        `CHK("t5_tlast", ia.m_axis_tlast, 1'b0)
        `CHK("t5_busy", busy_a, 1'b0)
        `CHK("t5_sready", ia.s_axis_tready, 1'b0)
        `CHK("t5_pidx", pidx_a, 4'd0)
        `CHK("t5_pass_done", pd_a, 1'b0)
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        run_frame(16, 32'h0000_8080, 1'b0, 1'b1);
        `CHK("t5_restart_timeout", timed_out, 1'b0)
        `CHK("t5_restart_count", out_n, 16)
        `CHK("t5_restart_sof", out_user[0][0], 1'b1)
        `CHK("t5_restart_data", out_data[0], 32'h1)
        `CHK("t5_restart_pidx", acc_pidx[0], 4'd0)
        @(posedge ACLK); #1;

        // Test 6: single line, single pass, no gap
        en_c = 1'b1; ic.m_axis_tready = 1'b1;
        @(posedge ACLK); #1;
        en_c = 1'b0;
        sent = 0; fdone = 0; got_first = 0; first_user = 2'b00;
        pd_at_fd = 1'b0; tl_at_fd = 1'b0; d_at_fd = '0;
        for (int c = 0; c < 40 && !fdone; c++) begin
            ic.s_axis_tvalid = (sent < 4);
            ic.s_axis_tdata  = 32'(sent + 1);
            ic.s_axis_tlast  = (sent == 3);
            @(negedge ACLK);
            if (ic.m_axis_tvalid && ic.m_axis_tready) begin
                if (!got_first) begin first_user = ic.m_axis_tuser; got_first = 1; end
                if (fd_c) begin
                    fdone = 1; pd_at_fd = pd_c; tl_at_fd = ic.m_axis_tlast; d_at_fd = ic.m_axis_tdata;
                end
            end
            if (ic.s_axis_tvalid && ic.s_axis_tready) begin
                acc_cyc[sent] = c;
                sent++;
            end
            @(posedge ACLK); #1;
        end
        ic.s_axis_tvalid = 1'b0; ic.s_axis_tlast = 1'b0;
        `CHK("t6_frame_done_seen", fdone, 1'b1)
        `CHK("t6_back_to_back", acc_cyc[3] - acc_cyc[0], 3)
        `CHK("t6_pass_done_coincide", pd_at_fd, 1'b1)
        `CHK("t6_tlast", tl_at_fd, 1'b1)
        `CHK("t6_last_data", d_at_fd, 32'h4)
        `CHK("t6_first_sof", first_user, 2'b01)
        `CHK("t6_err_long", el_c, 1'b0)
        `CHK("t6_busy_after", busy_c, 1'b0)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
